// File: rtl/code_lock_ctrl_pkg.sv
// Shared definitions for the 3-digit code lock: digit type, state encodings
// and a small digit helper.
package code_lock_ctrl_pkg;

    localparam int DIGIT_W = 2;
    localparam int CODE_W  = 3 * DIGIT_W;

    typedef logic [DIGIT_W-1:0] digit_t;

    localparam digit_t EMPTY_DIGIT = 2'd0;

    // Display order: d7 is the first digit entered, d5 the last.
    typedef struct packed {
        digit_t d7;
        digit_t d6;
        digit_t d5;
    } code_t;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ENTRY = 3'd1;
    localparam logic [2:0] ST_CHECK = 3'd2;
    localparam logic [2:0] ST_PASS  = 3'd3;
    localparam logic [2:0] ST_FAIL  = 3'd4;
    localparam logic [2:0] ST_LOCK  = 3'd5;

    function automatic logic digit_is_empty(input digit_t d);
        return d == EMPTY_DIGIT;
    endfunction

endpackage

// File: rtl/code_lock_ctrl_btn_debounce.sv
// Button conditioner: 2-flop synchroniser, stable-level counter and a
// one-cycle pulse on each accepted rising edge.
module btn_debounce
    import code_lock_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 200000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic pulse
);

    localparam int             CW     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_TC = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_meta;
    logic          sync_q;
    logic          stable;
    logic          stable_q;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_meta <= 1'b0;
            sync_q    <= 1'b0;
            stable    <= 1'b0;
            stable_q  <= 1'b0;
            pulse     <= 1'b0;
            cnt       <= '0;
        end else begin
            sync_meta <= btn;
            sync_q    <= sync_meta;
            stable_q  <= stable;
            pulse     <= stable & ~stable_q;
            // Any sample agreeing with the accepted level restarts the count.
            if (sync_q != stable) begin
                if (cnt == CNT_TC) begin
                    stable <= sync_q;
                    cnt    <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/code_lock_ctrl.sv
// 3-digit code lock entry/check controller feeding the display driver.
// Optional lockout after repeated failures: define CODE_LOCK_LOCKOUT_EN.
//
//   state    | meaning
//   ---------+-------------------------------------------------
//   ST_IDLE  | no digits held, waiting for first ENTER
//   ST_ENTRY | 1 or 2 digits captured
//   ST_CHECK | single cycle: compare code with PASSWORD
//   ST_PASS  | flag0 shown for RESULT_CYCLES or until CLEAR
//   ST_FAIL  | flagf shown for RESULT_CYCLES or until CLEAR
//   ST_LOCK  | lockout, flagf shown, inputs ignored (lockout build only)
module code_lock_ctrl
    import code_lock_ctrl_pkg::*;
#(
    parameter int               DEBOUNCE_CYCLES = 200000,
    parameter logic [CODE_W-1:0] PASSWORD       = 6'b011011,
    parameter int               RESULT_CYCLES   = 100000000,
    parameter int               MAX_FAIL        = 3,
    parameter int               LOCKOUT_CYCLES  = 500000000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   sw,
    input  logic         btn_enter,
    input  logic         btn_clear,
    output logic [1:0]   num7,
    output logic [1:0]   num6,
    output logic [1:0]   num5,
    output logic         flag0,
    output logic         flagf
);

    localparam logic [31:0] RES_TC = 32'(RESULT_CYCLES - 1);

    logic        enter_pulse;
    logic        clear_pulse;
    digit_t      sw_meta;
    digit_t      sw_sync;
    logic [2:0]  state;
    code_t       code_q;
    logic [1:0]  slot;
    logic [31:0] timer;
    logic        timer_done;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter_db (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_enter),
        .pulse (enter_pulse)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear_db (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_clear),
        .pulse (clear_pulse)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sw_meta <= EMPTY_DIGIT;
            sw_sync <= EMPTY_DIGIT;
        end else begin
            sw_meta <= sw;
            sw_sync <= sw_meta;
        end
    end

`ifdef CODE_LOCK_LOCKOUT_EN
    localparam int              FW       = $clog2(MAX_FAIL + 1);
    localparam logic [FW-1:0]   FAIL_MAX = FW'(MAX_FAIL);
    localparam logic [31:0]     LOCK_TC  = 32'(LOCKOUT_CYCLES - 1);

    logic [FW-1:0] fail_cnt;
    logic          lock_done;

    assign lock_done = (state == ST_LOCK) && (timer == LOCK_TC);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fail_cnt <= '0;
        end else if (state == ST_CHECK) begin
            if (code_q == PASSWORD) begin
                fail_cnt <= '0;
            end else if (fail_cnt != FAIL_MAX) begin
                fail_cnt <= fail_cnt + FW'(1);
            end
        end else if (lock_done) begin
            fail_cnt <= '0;
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = (MAX_FAIL == 0) ^ (LOCKOUT_CYCLES == 0);
`endif

    assign timer_done = (timer == RES_TC);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= ST_IDLE;
            code_q <= '0;
            slot   <= 2'd0;
            timer  <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_ENTRY: begin
                    // CLEAR has priority over a simultaneous ENTER.
                    if (clear_pulse) begin
                        code_q <= '0;
                        slot   <= 2'd0;
                        state  <= ST_IDLE;
                    end else if (enter_pulse && !digit_is_empty(sw_sync)) begin
                        case (slot)
                            2'd0: begin
                                code_q.d7 <= sw_sync;
                                slot      <= 2'd1;
                                state     <= ST_ENTRY;
                            end
                            2'd1: begin
                                code_q.d6 <= sw_sync;
                                slot      <= 2'd2;
                            end
                            default: begin
                                code_q.d5 <= sw_sync;
                                slot      <= 2'd0;
                                state     <= ST_CHECK;
                            end
                        endcase
                    end
                end
                ST_CHECK: begin
                    timer <= '0;
                    state <= (code_q == PASSWORD) ? ST_PASS : ST_FAIL;
                end
                ST_PASS: begin
                    if (clear_pulse || timer_done) begin
                        code_q <= '0;
                        state  <= ST_IDLE;
                    end else begin
                        timer <= timer + 32'd1;
                    end
                end
                ST_FAIL: begin
                    if (clear_pulse || timer_done) begin
                        code_q <= '0;
                        timer  <= '0;
`ifdef CODE_LOCK_LOCKOUT_EN
                        state  <= (fail_cnt == FAIL_MAX) ? ST_LOCK : ST_IDLE;
`else
                        state  <= ST_IDLE;
`endif
                    end else begin
                        timer <= timer + 32'd1;
                    end
                end
`ifdef CODE_LOCK_LOCKOUT_EN
                ST_LOCK: begin
                    if (lock_done) begin
                        state <= ST_IDLE;
                    end else begin
                        timer <= timer + 32'd1;
                    end
                end
`endif
                default: begin
                    state  <= ST_IDLE;
                    code_q <= '0;
                    slot   <= 2'd0;
                end
            endcase
        end
    end

    assign num7  = code_q.d7;
    assign num6  = code_q.d6;
    assign num5  = code_q.d5;
    assign flag0 = (state == ST_PASS);
    assign flagf = (state == ST_FAIL) || (state == ST_LOCK);

endmodule
